// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath stages.
package cnn_pkg;

    localparam int POOL_MAX = 0;
    localparam int POOL_AVG = 1;

    // Default pixel width shared with the convolution stages.
    localparam int CNN_DW   = 13;

    // Row role inside a 2x2 pooling frame.
    typedef enum logic [1:0] {
        S_FILL = 2'd0,  // even row: horizontal pairs go into the line buffer
        S_EMIT = 2'd1,  // odd row: pairs combine with the buffer and emit
        S_DROP = 2'd2   // trailing row of an odd-height map: discarded
    } pool_state_e;

endpackage

// File: rtl/pool_lane.sv
// One channel of the 2x2 pooling datapath: pair register, horizontal and
// vertical reduction, optional ReLU. Control comes from pool_relu_stream.
module pool_lane
    import cnn_pkg::*;
#(
    parameter int DW        = CNN_DW,
    parameter int POOL_MODE = POOL_MAX,
    parameter int RELU_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_i,   // capture the even-column pixel
    input  logic signed [DW-1:0] pix_i,   // current pixel
    input  logic signed [DW:0]   lb_i,    // line-buffer entry for this column pair
    output logic signed [DW:0]   hred_o,  // horizontal reduction of the pair
    output logic signed [DW-1:0] res_o    // pooled, rectified, truncated result
);

    logic signed [DW-1:0] pair_q;
    logic signed [DW:0]   pix_x;
    logic signed [DW:0]   pair_x;
    logic signed [DW+1:0] hred_x;
    logic signed [DW+1:0] lb_x;
    logic signed [DW+1:0] vsum;
    logic signed [DW+1:0] pooled;

    // Hold the left pixel of each horizontal pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q <= '0;
        end else if (cap_i) begin
            pair_q <= pix_i;
        end
    end

    assign pix_x  = {pix_i[DW-1], pix_i};
    assign pair_x = {pair_q[DW-1], pair_q};

    // Horizontal reduction: one extra bit keeps the average-mode sum exact.
    always_comb begin
        if (POOL_MODE == POOL_AVG) begin
            hred_o = pair_x + pix_x;
        end else begin
            hred_o = (pix_x > pair_x) ? pix_x : pair_x;
        end
    end

    // Vertical reduction with the buffered row, then ReLU and truncation.
    // The arithmetic shift floors toward -inf, matching a divide-by-4 of
    // the window sum rounded down.
    always_comb begin
        hred_x = {hred_o[DW], hred_o};
        lb_x   = {lb_i[DW], lb_i};
        vsum   = hred_x + lb_x;
        if (POOL_MODE == POOL_AVG) begin
            pooled = vsum >>> 2;
        end else begin
            pooled = (hred_x > lb_x) ? hred_x : lb_x;
        end
        if ((RELU_EN != 0) && pooled[DW+1]) begin
            pooled = '0;
        end
        res_o = pooled[DW-1:0];
    end

endmodule

// File: rtl/pool_relu_stream.sv
// Streaming 2x2/stride-2 pooling with optional ReLU over CH channels.
// Raster-order input, one half-row line buffer, registered output with
// valid/ready flow control.
module pool_relu_stream
    import cnn_pkg::*;
#(
    parameter int DW        = CNN_DW,
    parameter int CH        = 5,
    parameter int W         = 4,
    parameter int H         = 4,
    parameter int POOL_MODE = POOL_MAX,
    parameter int RELU_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*DW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*DW-1:0] out_data,
    output logic             out_last,
    output logic             frame_done
);

    localparam int CW     = $clog2(W);
    localparam int RW     = $clog2(H);
    localparam int LBN    = W / 2;
    localparam int LAW    = (LBN > 1) ? $clog2(LBN) : 1;
    localparam int LW     = DW + 1;
    // Bottom-right pixel of the last complete window in the frame.
    localparam int LAST_R = 2 * (H / 2) - 1;
    localparam int LAST_C = 2 * (W / 2) - 1;

    pool_state_e        state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic               out_valid_q;
    logic [CH*DW-1:0]   out_data_q;
    logic               out_last_q;
    logic               frame_done_q;

    logic [CH*LW-1:0]   lb_q [LBN];
    logic [CH*LW-1:0]   hred_all;
    logic [CH*DW-1:0]   res_all;

    logic               acc;
    logic               col_end;
    logic               row_end;
    logic               odd_col;
    logic [LAW-1:0]     lb_addr;
    logic               fill_wr;
    logic               emit;

    assign in_ready   = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

    assign acc     = in_valid && in_ready;
    assign col_end = (col_q == CW'(W - 1));
    assign row_end = (row_q == RW'(H - 1));
    assign odd_col = col_q[0];
    assign lb_addr = LAW'(col_q >> 1);
    // For odd W the trailing column is even, so it never writes or emits.
    assign fill_wr = acc && odd_col && (state_q == S_FILL);
    assign emit    = acc && odd_col && (state_q == S_EMIT);

    for (genvar g = 0; g < CH; g++) begin : g_lane
        pool_lane #(
            .DW        (DW),
            .POOL_MODE (POOL_MODE),
            .RELU_EN   (RELU_EN)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .cap_i  (acc && !odd_col),
            .pix_i  (in_data[g*DW +: DW]),
            .lb_i   (lb_q[lb_addr][g*LW +: LW]),
            .hred_o (hred_all[g*LW +: LW]),
            .res_o  (res_all[g*DW +: DW])
        );
    end

    // State and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Next raster position and row role, advanced only on accepted beats.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (acc) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
                case (state_q)
                    S_FILL:  state_d = S_EMIT;
                    S_EMIT: begin
                        if (row_end) begin
                            state_d = S_FILL;
                        end else if (row_q == RW'(H - 2)) begin
                            state_d = S_DROP;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                    default: state_d = S_FILL;
                endcase
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Even rows park their horizontal reductions for the row below.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            lb_q[lb_addr] <= hred_all;
        end
    end

    // Output register: a new result wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= acc && col_end && row_end;
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_all;
                out_last_q  <= (row_q == RW'(LAST_R)) && (col_q == CW'(LAST_C));
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_relu_stream.sv
// Directed bench for pool_relu_stream: max/avg modes, ReLU on/off,
// odd dimensions, backpressure, mid-frame reset and back-to-back frames.
module tb_pool_relu_stream;

    localparam int DW = 13;
    localparam int CH = 5;
    localparam int BW = CH * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          v4, r4, v5;
    logic [BW-1:0] d4, d5;

    logic          ir_m, ir_a, ir_n, ir_o;
    logic          ov_m, ov_a, ov_n, ov_o;
    logic [BW-1:0] od_m, od_a, od_n, od_o;
    logic          ol_m, ol_a, ol_n, ol_o;
    logic          fd_m, fd_a, fd_n, fd_o;

    int ncmp = 0;
    int nfail = 0;

    logic [BW-1:0] q_d [4][$];
    logic          q_l [4][$];

    pool_relu_stream #(.DW(DW), .CH(CH), .W(4), .H(4), .POOL_MODE(0), .RELU_EN(1)) u_max (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir_m), .in_data(d4),
        .out_valid(ov_m), .out_ready(r4), .out_data(od_m), .out_last(ol_m), .frame_done(fd_m));

    pool_relu_stream #(.DW(DW), .CH(CH), .W(4), .H(4), .POOL_MODE(1), .RELU_EN(1)) u_avg (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir_a), .in_data(d4),
        .out_valid(ov_a), .out_ready(r4), .out_data(od_a), .out_last(ol_a), .frame_done(fd_a));

    pool_relu_stream #(.DW(DW), .CH(CH), .W(4), .H(4), .POOL_MODE(1), .RELU_EN(0)) u_avgn (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir_n), .in_data(d4),
        .out_valid(ov_n), .out_ready(r4), .out_data(od_n), .out_last(ol_n), .frame_done(fd_n));

    pool_relu_stream #(.DW(DW), .CH(CH), .W(5), .H(5), .POOL_MODE(0), .RELU_EN(1)) u_odd (
        .clk(clk), .rst(rst), .in_valid(v5), .in_ready(ir_o), .in_data(d5),
        .out_valid(ov_o), .out_ready(1'b1), .out_data(od_o), .out_last(ol_o), .frame_done(fd_o));

    // Record every transferred output beat, sampled away from the clock edge.
    always @(negedge clk) begin
        if (ov_m && r4) begin q_d[0].push_back(od_m); q_l[0].push_back(ol_m); end
        if (ov_a && r4) begin q_d[1].push_back(od_a); q_l[1].push_back(ol_a); end
        if (ov_n && r4) begin q_d[2].push_back(od_n); q_l[2].push_back(ol_n); end
        if (ov_o)       begin q_d[3].push_back(od_o); q_l[3].push_back(ol_o); end
    end

    // Channel c carries value p + step*c.
    function automatic logic [BW-1:0] pk(input int p, input int step);
        logic [BW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c*DW +: DW] = DW'(p + step * c);
        return r;
    endfunction

    function automatic logic [BW-1:0] qget(input int k, input int i);
        if (i < q_d[k].size()) return q_d[k][i];
        return 'x;
    endfunction

    function automatic logic qlast(input int k, input int i);
        if (i < q_l[k].size()) return q_l[k][i];
        return 1'bx;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One input beat; waits (bounded) for in_ready, returns #1 after the transfer edge.
    task automatic beat(input int bus, input logic [BW-1:0] d);
        int n;
        n = 0;
        if (bus == 0) begin v4 = 1'b1; d4 = d; end
        else          begin v5 = 1'b1; d5 = d; end
        forever begin
            @(negedge clk);
            if ((bus == 0) ? ir_m : ir_o) break;
            n++;
            if (n > 50) begin
                ncmp++;
                nfail++;
                $error("FAIL beat_timeout: observed in_ready=0 expected 1 within 50 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        v4 = 1'b0;
        v5 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Four consecutive results from base; only the last carries out_last.
    task automatic chkframe(input string tag, input int k, input int base,
                            input int e0, input int e1, input int e2, input int e3,
                            input int step);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_data%0d", tag, i), qget(k, base + i), pk(e[i], step));
            chk($sformatf("%s_last%0d", tag, i), BW'(qlast(k, base + i)), BW'(i == 3));
        end
    endtask

    initial begin
        int b;
        rst = 1'b1; v4 = 1'b0; v5 = 1'b0; r4 = 1'b1; d4 = '0; d5 = '0;
        idle(2);

        // Reset state
        chk("rst_out_valid", BW'(ov_m), BW'(0));
        chk("rst_out_data",  od_m, '0);
        chk("rst_out_last",  BW'(ol_m), BW'(0));
        chk("rst_frame_done", BW'(fd_m), BW'(0));
        chk("rst_in_ready",  BW'(ir_m), BW'(1));
        chk("rst_odd_valid", BW'(ov_o), BW'(0));
        rst = 1'b0;

        // Ramp frame into all three 4x4 instances
        for (int p = 0; p < 15; p++) beat(0, pk(p, 16));
        chk("fd_before_last", BW'(fd_m), BW'(0));
        beat(0, pk(15, 16));
        chk("fd_after_last", BW'(fd_m), BW'(1));
        idle(1);
        chk("fd_one_cycle", BW'(fd_m), BW'(0));
        idle(1);
        chk("ramp_count_max", BW'(q_d[0].size()), BW'(4));
        chkframe("max_ramp",  0, 0, 5, 7, 13, 15, 16);
        chkframe("avg_ramp",  1, 0, 2, 4, 10, 12, 16);
        chkframe("avgn_ramp", 2, 0, 2, 4, 10, 12, 16);

        // Negative windows {-1,-2,-2,-2}
        b = q_d[0].size();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                beat(0, pk(((r % 2 == 0) && (c % 2 == 0)) ? -1 : -2, 0));
        idle(2);
        chkframe("max_neg_relu",  0, b, 0, 0, 0, 0, 0);
        chkframe("avg_neg_relu",  1, b, 0, 0, 0, 0, 0);
        chkframe("avg_neg_floor", 2, b, -2, -2, -2, -2, 0);

        // Backpressure on the first output
        b = q_d[0].size();
        for (int p = 0; p < 6; p++) beat(0, pk(p, 16));
        r4 = 1'b0;
        v4 = 1'b1;
        d4 = pk(6, 16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), BW'(ov_m), BW'(1));
            chk($sformatf("bp_data%0d", i), od_m, pk(5, 16));
            chk($sformatf("bp_in_ready%0d", i), BW'(ir_m), BW'(0));
        end
        @(posedge clk);
        #1;
        r4 = 1'b1;
        for (int p = 6; p < 16; p++) beat(0, pk(p, 16));
        idle(2);
        chk("bp_count", BW'(q_d[0].size() - b), BW'(4));
        chkframe("bp_max", 0, b, 5, 7, 13, 15, 16);

        // Reset mid-frame, then two back-to-back frames
        for (int p = 0; p < 10; p++) beat(0, pk(p, 16));
        rst = 1'b1;
        idle(1);
        chk("midrst_out_valid", BW'(ov_m), BW'(0));
        rst = 1'b0;
        b = q_d[0].size();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 16; p++) beat(0, pk(p, 16));
        idle(2);
        chk("b2b_count", BW'(q_d[0].size() - b), BW'(8));
        chkframe("b2b_frame0", 0, b,     5, 7, 13, 15, 16);
        chkframe("b2b_frame1", 0, b + 4, 5, 7, 13, 15, 16);

        // 5x5 max pool: trailing column and row are discarded
        b = q_d[3].size();
        for (int p = 0; p < 20; p++) beat(1, pk(p, 16));
        chk("odd_fd_row3", BW'(fd_o), BW'(0));
        for (int p = 20; p < 24; p++) beat(1, pk(p, 16));
        chk("odd_fd_pre", BW'(fd_o), BW'(0));
        chk("odd_count_pre", BW'(q_d[3].size() - b), BW'(4));
        beat(1, pk(24, 16));
        chk("odd_fd_post", BW'(fd_o), BW'(1));
        idle(2);
        chk("odd_count_post", BW'(q_d[3].size() - b), BW'(4));
        chkframe("odd_max", 3, b, 6, 8, 16, 18, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
